acc8_unit: RTL
==============

# acc8_unit

Sequential 8-bit accumulator that consumes a burst of operands through a valid/ready stream and sums them with an 8-bit add-with-carry datapath. It counts carry-outs across the burst and presents the final sum and carry count on a held output handshake. It sits directly downstream of operand sources and wraps the 8-bit adder as its arithmetic core.

## Interface
- COUNT_W, default 4: width of burst length and carry counter; max burst = 2^COUNT_W-1.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin burst; sampled only in IDLE
- len  in  COUNT_W  number of operands in burst; sampled with start
- in_valid  in  1  operand valid
- in_data  in  8  operand
- in_ready  out  1  operand accepted when in_valid && in_ready
- out_valid  out  1  result valid
- out_sum  out  8  accumulated sum
- out_carries  out  COUNT_W  number of carry-outs during burst, saturating
- out_ready  in  1  result consumed when out_valid && out_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, out_valid=0. On start && len!=0: remaining<=len, acc<=0, carries<=0, go ACC. On start && len==0: acc<=0, carries<=0, go DONE.
- ACC: in_ready=1. On accepted beat: {c,s}=acc+in_data; acc<=s (mod 256); if c, carries<=carries+1, holding at all-ones; remaining<=remaining-1; if remaining==1, go DONE. in_valid low: hold everything.
- DONE: out_valid=1, out_sum=acc, out_carries=carries; hold stable until out_valid && out_ready, then IDLE.
- start outside IDLE ignored; len change outside IDLE ignored.
- Reset (any state, mid-burst included): state=IDLE, acc=0, carries=0, remaining=0; partial burst discarded, no output.
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_carries=0, busy=0.

## Timing
- start at cycle 0 -> ACC from cycle 1; in_ready is state-decoded, no combinational path from in_valid.
- Throughput: one operand per cycle.
- Last beat accepted in cycle k -> out_valid asserted cycle k+1; minimum start-to-out_valid = len+1 cycles.
- len==0: out_valid at cycle 1.
- Handshake completes in DONE -> IDLE next cycle; a start in that same handshake cycle is ignored. Earliest new start is sampled the cycle after.
- All outputs registered or state-decoded.

## Configuration
- ACC8_SAT_EN defined: on a carry-out, acc<=8'hFF and stays 8'hFF for the rest of the burst. Carries still counted.
- Undefined: acc wraps modulo 256.

## Structure
- Shared package acc8_pkg: state enum (IDLE, ACC, DONE), DATA_W=8 constant.
- One sub-module: acc8_add, combinational 8-bit add with carry-in (tied 0) and carry-out, instantiated once in the datapath.

## Test plan
- len=3, data 10,20,30 back-to-back -> out_sum=60, out_carries=0, out_valid at cycle 4.
- len=2, data 200,100 -> out_sum=44, out_carries=1. With ACC8_SAT_EN: out_sum=255, out_carries=1.
- len=0 -> out_valid at cycle 1, out_sum=0, out_carries=0.
- len=4, in_valid low on alternate cycles, data 1,2,3,4 -> out_sum=10. out_ready held low 5 cycles -> outputs stable. start pulsed while busy -> ignored.
- len=15, all operands 255 -> out_sum=241, out_carries=14. COUNT_W=2, len=3, operands 255 -> out_carries=2.
- rst asserted after 2 beats of a len=5 burst -> outputs return to reset values immediately. New len=1 burst with data 7 -> out_sum=7.

Source files
------------

// File: rtl/acc8_pkg.sv
// acc8_pkg: shared types and constants for the acc8_unit accumulator.
//   DATA_W  - operand / sum width
//   state_e - control FSM states (idle, accumulating, result held)
package acc8_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/acc8_add.sv
// acc8_add: combinational DATA_W-bit adder with carry-in and carry-out.
// Ports:
//   a_i, b_i  - addends
//   cin_i     - carry in
//   sum_o     - a_i + b_i + cin_i, modulo 2^DATA_W
//   cout_o    - carry out of the top bit
module acc8_add
   import acc8_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cin_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              cout_o
);

   logic [DATA_W:0] full;

   always_comb begin
      full = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
      sum_o  = full[DATA_W-1:0];
      cout_o = full[DATA_W];
   end

endmodule

// File: rtl/acc8_unit.sv
// acc8_unit: burst accumulator. Accepts len operands over a valid/ready stream, sums
// them with an 8-bit add, counts carry-outs (saturating) and holds the result on a
// valid/ready output until consumed.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   start, len              - begin a burst of len operands (sampled only when idle)
//   in_valid/in_ready/in_data - operand stream
//   out_valid/out_ready     - result handshake
//   out_sum, out_carries    - accumulated sum and carry-out count
//   busy                    - high whenever not idle
// Build option: define ACC8_SAT_EN to clamp the sum at 8'hFF on the first carry-out.
module acc8_unit
   import acc8_pkg::*;
#(
   parameter int unsigned COUNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_sum,
   output logic [COUNT_W-1:0] out_carries,
   input  logic               out_ready,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [COUNT_W-1:0] carries_q, carries_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;

   logic [DATA_W-1:0]  add_sum;
   logic               add_cout;

   acc8_add u_add (
      .a_i    (acc_q),
      .b_i    (in_data),
      .cin_i  (1'b0),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      carries_d   = carries_q;
      remaining_d = remaining_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               acc_d     = '0;
               carries_d = '0;
               if (len != '0) begin
                  remaining_d = len;
                  state_d     = StAcc;
               end else begin
                  state_d = StDone;
               end
            end
         end

         StAcc: begin
            if (in_valid) begin
`ifdef ACC8_SAT_EN
               // Once clamped, any further add either carries (re-clamps) or adds
               // zero, so the sum stays at all-ones without a separate flag.
               acc_d = add_cout ? '1 : add_sum;
`else
               acc_d = add_sum;
`endif
               if (add_cout && (carries_q != '1)) begin
                  carries_d = carries_q + COUNT_W'(1);
               end
               remaining_d = remaining_q - COUNT_W'(1);
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = StDone;
               end
            end
         end

         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         carries_q   <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         carries_q   <= carries_d;
         remaining_q <= remaining_d;
      end
   end

   // Outputs are state-decoded or straight from registers; no input-to-output paths.
   always_comb begin
      in_ready    = (state_q == StAcc);
      out_valid   = (state_q == StDone);
      busy        = (state_q != StIdle);
      out_sum     = acc_q;
      out_carries = carries_q;
   end

endmodule
